soma_array: RTL
===============

# soma_array

Time-multiplexed leaky integrate-and-fire soma for `N_NEURON` neurons, successor to the single-neuron soma.
- Inputs: weighted synaptic events (neuron id + signed weight) from the synapse stage.
- Each accepted event updates the addressed neuron's membrane potential; a per-timestep `tick` runs a leak/refractory sweep over all neurons.
- Threshold crossings are queued as timestamped spike events for the axon/router stage.
- Neuron constants are runtime-configurable through a small register port driven by the PN controller.

## Interface
Parameters:
- `N_NEURON`, 16: neurons held; `IDW = $clog2(N_NEURON)`.
- `VW`, 16: signed membrane potential / weight width.
- `TW`, 16: timestamp width.
- `FIFO_DEPTH`, 8: spike output queue depth (power of 2).

Ports:
- `clk`  in  1  clock, all logic rising-edge.
- `rst`  in  1  reset, asynchronous, active-low (asserted at 0).
- `cfg_we`  in  1  config write strobe.
- `cfg_addr`  in  3  0 `v_th`, 1 `v_reset`, 2 `leak_shift[3:0]`, 3 `refr_period[7:0]`, 4 `axon_delay[TW-1:0]`.
- `cfg_data`  in  max(VW,TW)  write data, low bits used per register.
- `tick`  in  1  timestep pulse.
- `in_valid` / `in_ready`  in/out  1  event handshake.
- `in_id`  in  IDW  target neuron.
- `in_weight`  in  VW  signed weight.
- `out_valid` / `out_ready`  out/in  1  spike handshake.
- `out_id`  out  IDW  spiking neuron.
- `out_time`  out  TW  spike delivery time.
- `busy`  out  1  sweep in progress.
- `tick_overrun`  out  1  sticky; a tick was lost.

## Operation
- State per neuron: signed `v[VW]` and `refr[8]`. Global: `ts[TW]`.
- Config defaults on reset: `v_th`=256, `v_reset`=0, `leak_shift`=4, `refr_period`=2, `axon_delay`=1.
- Config writes take effect the next cycle. Writes while `busy` are legal, but that sweep may mix old and new values.
- FSM `IDLE`, `SWEEP`.
- `in_ready = (state==IDLE) && !fifo_full`.
- Event handshake (`in_valid && in_ready`):
  - If `refr[id] != 0`, the event is consumed and discarded.
  - Otherwise `s = sat(v[id] + in_weight)`, saturating to [-2^(VW-1), 2^(VW-1)-1].
  - If `s >= v_th` (signed): `v[id] <= v_reset`, `refr[id] <= refr_period`, and push {`id`, `ts + axon_delay`} to the FIFO. The time sum wraps modulo 2^TW.
  - Otherwise `v[id] <= s`.
- `tick` in `IDLE`:
  - `ts <= ts+1` (wraps), `idx <= 0`, go to `SWEEP`.
  - An event handshaking in the same cycle completes first, using the old `ts`.
- `SWEEP`: each cycle visits neuron `idx`.
  - `v <= v - (v >>> leak_shift)`; `leak_shift`=0 zeroes `v`.
  - `refr <= refr - 1` if non-zero.
  - Leak never produces a spike.
  - After `idx == N_NEURON-1`, return to `IDLE`. If `tick_pend` is set, go straight back to `SWEEP` instead, clearing `tick_pend` and incrementing `ts`.
- `tick` during `SWEEP`:
  - Sets `tick_pend`.
  - If `tick_pend` is already set, the tick is dropped and `tick_overrun <= 1`, which stays set until reset.
- Output FIFO: standard valid/ready. Simultaneous push and pop are legal at any occupancy. The `!fifo_full` term in `in_ready` guarantees a push is never lost.

## Timing
- Event accepted at edge t: `v` updated at t. A resulting spike has `out_valid` high after edge t, when the FIFO was empty.
- Sweep occupies exactly `N_NEURON` cycles. `busy` is high in `SWEEP`.
- `in_ready` falls the cycle after `tick` is sampled in `IDLE`. It rises the cycle after the final visit, unless a pending tick chains the next sweep.
- Reset (async assert, any point, including mid-sweep):
  - All `v`, `refr`, `ts`, FIFO, `tick_pend` and `tick_overrun` cleared; config set to defaults; state `IDLE`.
  - Outputs: `out_valid`=0, `out_id`=0, `out_time`=0, `busy`=0, `tick_overrun`=0.
  - `in_ready`=1 (FIFO empty, `IDLE`).
- Deassertion is synchronised externally; no input is required to be quiet except the handshakes.

## Structure
- `soma_pkg`:
  - `CFG_VTH`..`CFG_AXON` address constants.
  - Default config values.
  - `spike_evt_t` struct {id, time}, parametrised through localparams.
  - State enum `soma_state_e`.
- Sub-module `spike_fifo` (parametrised depth/width, valid/ready both sides, `full` output).
- Neuron state held in flop arrays: combinational read, write at clock edge.

## Test plan
- Defaults; events to id 3 with weights 100, 100, 100 → `v`=100, 200, then spike: `out_id`=3, `out_time`=1, `v[3]`=0, `refr[3]`=2.
- After that spike, weight 300 to id 3 before a tick → discarded, no spike. After 2 ticks (both sweeps complete), weight 300 → spike with `out_time` = `ts`+1 = 3.
- `v[5]`=160, `leak_shift`=4, one tick → `v[5]`=150 after sweep. `busy` high exactly 16 cycles; `in_ready` low throughout.
- Saturation: weight 0x7FFF twice to id 0 with `v_th`=0x7FFF → first spikes. Then with `v_th` set above reach via negative weights -0x8000 twice → `v` clamps at -32768, no wrap.
- `out_ready`=0, 9 spiking events → 8 queued, `in_ready`=0 with the 9th held. Pulse `out_ready` once → 9th accepted the cycle after the pop.
- Three ticks during one sweep → one chained sweep, `tick_overrun`=1. Async reset mid-sweep → all outputs at reset values immediately, `in_ready`=1.

Source files
------------

// File: rtl/soma_pkg.sv
// Shared constants and types for the time-multiplexed LIF soma.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: config register addresses, reset defaults, spike event type, FSM state enum.
package soma_pkg;

    // Default-build widths for downstream consumers of spike_evt_t
    localparam int SOMA_IDW = 4;
    localparam int SOMA_TW  = 16;

    // Config register map
    localparam logic [2:0] CFG_VTH    = 3'd0;
    localparam logic [2:0] CFG_VRESET = 3'd1;
    localparam logic [2:0] CFG_LEAK   = 3'd2;
    localparam logic [2:0] CFG_REFR   = 3'd3;
    localparam logic [2:0] CFG_AXON   = 3'd4;

    // Reset values of the config registers
    localparam int DEF_VTH    = 256;
    localparam int DEF_VRESET = 0;
    localparam int DEF_LEAK   = 4;
    localparam int DEF_REFR   = 2;
    localparam int DEF_AXON   = 1;

    typedef struct packed {
        logic [SOMA_IDW-1:0] id;
        logic [SOMA_TW-1:0]  tstamp;
    } spike_evt_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SWEEP = 1'b1
    } soma_state_e;

endpackage

// File: rtl/spike_fifo.sv
// Generic flop-based FIFO carrying spike events to the axon stage.
// Latency: a push is visible at the output the cycle after the write edge.
// Backpressure: in_ready = !full; out_valid holds until out_ready pops.
// Ports: clk, rst (async active-low), in_valid/in_ready/in_data, out_valid/out_ready/out_data, full.
module spike_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         push;
    logic         pop;

    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign out_valid = (wr_ptr != rd_ptr);
    assign in_ready  = !full;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr[AW-1:0]];

    // Storage is cleared on reset so the output fields read zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= in_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/soma_array.sv
// Time-multiplexed leaky integrate-and-fire soma for N_NEURON neurons.
// Latency: event updates v at the accepting edge; a spike is on out_* the next cycle (empty FIFO).
// Backpressure: in_ready drops during a leak sweep or when the spike FIFO is full.
// Ports: clk, rst (async active-low), cfg_we/cfg_addr/cfg_data, tick, in_valid/in_ready/in_id/in_weight,
//        out_valid/out_ready/out_id/out_time, busy, tick_overrun.
module soma_array
    import soma_pkg::*;
#(
    parameter int N_NEURON   = 16,
    parameter int IDW        = $clog2(N_NEURON),
    parameter int VW         = 16,
    parameter int TW         = 16,
    parameter int FIFO_DEPTH = 8,
    localparam int CW        = (VW > TW) ? VW : TW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_we,
    input  logic [2:0]     cfg_addr,
    input  logic [CW-1:0]  cfg_data,
    input  logic           tick,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [IDW-1:0] in_id,
    input  logic [VW-1:0]  in_weight,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [IDW-1:0] out_id,
    output logic [TW-1:0]  out_time,
    output logic           busy,
    output logic           tick_overrun
);

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [TW-1:0]  tstamp;
    } spike_t;

    // Config registers
    logic signed [VW-1:0] v_th;
    logic signed [VW-1:0] v_reset;
    logic [3:0]           leak_shift;
    logic [7:0]           refr_period;
    logic [TW-1:0]        axon_delay;

    // Neuron state
    logic signed [VW-1:0] v_mem    [N_NEURON];
    logic [7:0]           refr_mem [N_NEURON];

    // Sequencer state
    soma_state_e    state_q, state_d;
    logic [IDW-1:0] idx_q, idx_d;
    logic [TW-1:0]  ts_q, ts_d;
    logic           pend_q, pend_d;
    logic           ovr_q, ovr_d;

    // Event datapath
    logic                 fifo_full;
    logic                 fifo_in_ready;
    logic                 ev_fire;
    logic                 ev_live;
    logic                 ev_spike;
    logic signed [VW-1:0] v_cur;
    logic signed [VW:0]   sum_ext;
    logic signed [VW-1:0] s_sat;
    logic signed [VW-1:0] v_sw;
    logic signed [VW-1:0] v_leak;
    spike_t               push_evt;
    spike_t               head_evt;

    assign in_ready = (state_q == S_IDLE) && !fifo_full;
    assign ev_fire  = in_valid && in_ready;
    assign v_cur    = v_mem[in_id];
    assign sum_ext  = {v_cur[VW-1], v_cur} + {in_weight[VW-1], in_weight};

    // Clamp when the extended sum's top two bits disagree
    always_comb begin
        s_sat = sum_ext[VW-1:0];
        if (sum_ext[VW] != sum_ext[VW-1]) begin
            s_sat = sum_ext[VW] ? {1'b1, {(VW-1){1'b0}}} : {1'b0, {(VW-1){1'b1}}};
        end
    end

    // Refractory neurons swallow the event without touching v
    assign ev_live  = ev_fire && (refr_mem[in_id] == 8'd0);
    assign ev_spike = ev_live && (s_sat >= v_th);

    // v - v>>>k tends toward zero from either sign and cannot overflow; k=0 gives 0
    assign v_sw   = v_mem[idx_q];
    assign v_leak = v_sw - (v_sw >>> leak_shift);

    assign push_evt.id     = in_id;
    assign push_evt.tstamp = ts_q + axon_delay;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_th        <= VW'(DEF_VTH);
            v_reset     <= VW'(DEF_VRESET);
            leak_shift  <= 4'(DEF_LEAK);
            refr_period <= 8'(DEF_REFR);
            axon_delay  <= TW'(DEF_AXON);
        end else if (cfg_we) begin
            case (cfg_addr)
                CFG_VTH:    v_th        <= cfg_data[VW-1:0];
                CFG_VRESET: v_reset     <= cfg_data[VW-1:0];
                CFG_LEAK:   leak_shift  <= cfg_data[3:0];
                CFG_REFR:   refr_period <= cfg_data[7:0];
                CFG_AXON:   axon_delay  <= cfg_data[TW-1:0];
                default:    ;
            endcase
        end
    end

    // Events only land in IDLE and sweep visits only in SWEEP, so the two write ports never collide
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_NEURON; i++) begin
                v_mem[i]    <= '0;
                refr_mem[i] <= '0;
            end
        end else if (state_q == S_SWEEP) begin
            v_mem[idx_q] <= v_leak;
            if (refr_mem[idx_q] != 8'd0) begin
                refr_mem[idx_q] <= refr_mem[idx_q] - 8'd1;
            end
        end else if (ev_live) begin
            if (ev_spike) begin
                v_mem[in_id]    <= v_reset;
                refr_mem[in_id] <= refr_period;
            end else begin
                v_mem[in_id] <= s_sat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            ts_q    <= '0;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ts_q    <= ts_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ts_d    = ts_q;
        pend_d  = pend_q;
        ovr_d   = ovr_q;
        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    ts_d    = ts_q + 1'b1;
                    idx_d   = '0;
                    state_d = S_SWEEP;
                end
            end
            S_SWEEP: begin
                idx_d = idx_q + 1'b1;
                // Only one tick can wait; a second one is lost and flagged
                if (tick) begin
                    if (pend_q) begin
                        ovr_d = 1'b1;
                    end else begin
                        pend_d = 1'b1;
                    end
                end
                if (idx_q == IDW'(N_NEURON - 1)) begin
                    idx_d = '0;
                    if (pend_q) begin
                        pend_d  = 1'b0;
                        ts_d    = ts_q + 1'b1;
                        state_d = S_SWEEP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy         = (state_q == S_SWEEP);
    assign tick_overrun = ovr_q;

    // in_ready already excludes a full FIFO, so every spike push is accepted
    spike_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (IDW + TW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (ev_spike),
        .in_ready  (fifo_in_ready),
        .in_data   (push_evt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head_evt),
        .full      (fifo_full)
    );

    assign out_id   = head_evt.id;
    assign out_time = head_evt.tstamp;

endmodule
